// File: rtl/sm_spiframe.sv
// SPI write-frame decoder: address then data words (MSB first), one wr_en per word.
// Optional macro SPI_BURST_EN: stay in DATA and auto-increment the address after each word.
module sm_spiframe #(
  parameter  int ADDR_BYTES = 1,
  parameter  int DATA_BYTES = 1,
  localparam int ADDR_W     = 8*ADDR_BYTES,
  localparam int DATA_W     = 8*DATA_BYTES
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              nss_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_en_o,
  output logic              frame_err_o,
  output logic [1:0]        state_o
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADDR = 2'b01;
  localparam logic [1:0] DATA = 2'b10;
  localparam logic [1:0] HOLD = 2'b11;

  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES-1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES-1);

  logic              nss_q, rv_q;
  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;
  logic              wrote_q, wrote_d;   // at least one word committed this frame
  logic              ovr_q, ovr_d;       // overrun already reported this frame

  logic              start, bs;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;

  assign start   = nss_q & ~nss_i;
  assign bs      = rv_q & ~rx_valid_i;
  assign addr_sh = (addr_q << 8) | ADDR_W'(rx_byte_i);
  assign data_sh = (data_q << 8) | DATA_W'(rx_byte_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    wrote_d   = wrote_q;
    ovr_d     = ovr_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = ADDR;
        cnt_d   = '0;
        wrote_d = 1'b0;
        ovr_d   = 1'b0;
      end
    end else if (nss_i) begin
      // Frame closed: a partial word, address-only frame or a byte racing nss is a truncation.
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = (state_q == ADDR) ||
                ((state_q == DATA) && ((cnt_q != '0) || !wrote_q || bs));
    end else begin
      case (state_q)
        ADDR: if (bs) begin
          addr_d = addr_sh;
          if (cnt_q == A_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        DATA: if (bs) begin
          data_d = data_sh;
          if (cnt_q == D_LAST) begin
            wr_en_d   = 1'b1;
            wr_data_d = data_sh;
            wr_addr_d = addr_q;
            cnt_d     = '0;
            wrote_d   = 1'b1;
`ifdef SPI_BURST_EN
            addr_d    = addr_q + 1'b1;
`else
            state_d   = HOLD;
`endif
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: if (bs && !ovr_q) begin
          err_d = 1'b1;
          ovr_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nss_q     <= 1'b0;
      rv_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wrote_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      nss_q     <= nss_i;
      rv_q      <= rx_valid_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      wrote_q   <= wrote_d;
      ovr_q     <= ovr_d;
    end
  end

  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_en_o     = wr_en_q;
  assign frame_err_o = err_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_sm_spiframe.sv
// Directed bench for sm_spiframe: 8/8 and 16/16 instances share one SPI stimulus stream.
module tb_sm_spiframe;
  logic       clk = 1'b0, reset = 1'b1, nss = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0]  wa8, wd8;
  logic [15:0] wa16, wd16;
  logic        we8, fe8, we16, fe16;
  logic [1:0]  st8, st16;

  always #5 clk = ~clk;

  sm_spiframe #(.ADDR_BYTES(1), .DATA_BYTES(1)) u8 (
    .clk_i(clk), .reset_i(reset), .nss_i(nss), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .wr_addr_o(wa8), .wr_data_o(wd8), .wr_en_o(we8), .frame_err_o(fe8), .state_o(st8));

  sm_spiframe #(.ADDR_BYTES(2), .DATA_BYTES(2)) u16 (
    .clk_i(clk), .reset_i(reset), .nss_i(nss), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .wr_addr_o(wa16), .wr_data_o(wd16), .wr_en_o(we16), .frame_err_o(fe16), .state_o(st16));

  typedef struct { logic [15:0] a; logic [15:0] d; int c; } wr_t;
  wr_t q8[$], q16[$];
  int  cyc = 0, ne8 = 0, ne16 = 0, ec8 = -1;
  int  vec = 0, bad = 0, bs_cyc = 0, nss_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we8)  q8.push_back('{16'(wa8), 16'(wd8), cyc});
    if (we16) q16.push_back('{wa16, wd16, cyc});
    if (fe8) begin ne8++; ec8 = cyc; end
    if (fe16) ne16++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clr();
    q8.delete(); q16.delete(); ne8 = 0; ne16 = 0; ec8 = -1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; tick(2);
    rx_valid = 1'b0; bs_cyc = cyc; tick(2);
  endtask
  task automatic open_f();
    nss = 1'b0; tick(2);
  endtask
  task automatic close_f();
    tick(1); nss = 1'b1; nss_cyc = cyc; tick(3);
  endtask

  task automatic test_reset();
    tick(3); reset = 1'b0; tick(1);
    vec++; if (st8 !== 2'b00) begin bad++; $display("FAIL reset_state got %0h want 0", st8); end
    vec++; if (we8 !== 1'b0 || fe8 !== 1'b0) begin bad++; $display("FAIL reset_strobes got %b%b want 00", we8, fe8); end
    vec++; if (wa8 !== 8'h00 || wd8 !== 8'h00) begin bad++; $display("FAIL reset_regs got %h/%h want 00/00", wa8, wd8); end
    vec++; if (wa16 !== 16'h0 || wd16 !== 16'h0 || st16 !== 2'b00) begin bad++; $display("FAIL reset_u16 got %h/%h/%0h want 0", wa16, wd16, st16); end
  endtask

  task automatic test_single();
    clr(); open_f(); send(8'h12); send(8'h34); close_f();
    vec++; if (q8.size() != 1) begin bad++; $display("FAIL t1_count got %0d want 1", q8.size()); end
    else begin
      vec++; if (q8[0].a !== 16'h12 || q8[0].d !== 16'h34) begin bad++; $display("FAIL t1_word got %h/%h want 12/34", q8[0].a, q8[0].d); end
      vec++; if (q8[0].c != bs_cyc + 1) begin bad++; $display("FAIL t1_latency got %0d want %0d", q8[0].c, bs_cyc + 1); end
    end
    vec++; if (ne8 != 0) begin bad++; $display("FAIL t1_err got %0d want 0", ne8); end
  endtask

  task automatic test_wide();
    clr(); open_f(); send(8'h01); send(8'h02); send(8'h12); send(8'h34); close_f();
    vec++; if (q16.size() != 1) begin bad++; $display("FAIL t5_count got %0d want 1", q16.size()); end
    else begin
      vec++; if (q16[0].a !== 16'h0102 || q16[0].d !== 16'h1234) begin bad++; $display("FAIL t5_word got %h/%h want 0102/1234", q16[0].a, q16[0].d); end
      vec++; if (q16[0].c != bs_cyc + 1) begin bad++; $display("FAIL t5_latency got %0d want %0d", q16[0].c, bs_cyc + 1); end
    end
    vec++; if (ne16 != 0) begin bad++; $display("FAIL t5_err got %0d want 0", ne16); end
  endtask

  task automatic test_truncation();
    clr(); open_f(); send(8'h20); close_f();
    vec++; if (q8.size() != 0) begin bad++; $display("FAIL t4_writes got %0d want 0", q8.size()); end
    vec++; if (ne8 != 1) begin bad++; $display("FAIL t4_errcount got %0d want 1", ne8); end
    vec++; if (ec8 != nss_cyc + 1) begin bad++; $display("FAIL t4_errcyc got %0d want %0d", ec8, nss_cyc + 1); end
  endtask

  task automatic test_nss_race();
    clr(); open_f(); send(8'h30);
    rx_byte = 8'h40; rx_valid = 1'b1; tick(2);
    rx_valid = 1'b0; nss = 1'b1; tick(3);
    vec++; if (q8.size() != 0) begin bad++; $display("FAIL race_writes got %0d want 0", q8.size()); end
    vec++; if (ne8 != 1) begin bad++; $display("FAIL race_err got %0d want 1", ne8); end
  endtask

`ifdef SPI_BURST_EN
  task automatic test_burst();
    clr(); open_f(); send(8'h10); send(8'hAA); send(8'hBB); send(8'hCC); close_f();
    vec++; if (q8.size() != 3) begin bad++; $display("FAIL t2_count got %0d want 3", q8.size()); end
    else begin
      vec++; if (q8[0].a !== 16'h10 || q8[0].d !== 16'hAA) begin bad++; $display("FAIL t2_w0 got %h/%h want 10/aa", q8[0].a, q8[0].d); end
      vec++; if (q8[1].a !== 16'h11 || q8[1].d !== 16'hBB) begin bad++; $display("FAIL t2_w1 got %h/%h want 11/bb", q8[1].a, q8[1].d); end
      vec++; if (q8[2].a !== 16'h12 || q8[2].d !== 16'hCC) begin bad++; $display("FAIL t2_w2 got %h/%h want 12/cc", q8[2].a, q8[2].d); end
    end
    vec++; if (ne8 != 0) begin bad++; $display("FAIL t2_err got %0d want 0", ne8); end
  endtask

  task automatic test_wrap();
    clr(); open_f(); send(8'hFF); send(8'h01); send(8'h02); close_f();
    vec++; if (q8.size() != 2) begin bad++; $display("FAIL t3_count got %0d want 2", q8.size()); end
    else begin
      vec++; if (q8[0].a !== 16'hFF || q8[0].d !== 16'h01) begin bad++; $display("FAIL t3_w0 got %h/%h want ff/01", q8[0].a, q8[0].d); end
      vec++; if (q8[1].a !== 16'h00 || q8[1].d !== 16'h02) begin bad++; $display("FAIL t3_w1 got %h/%h want 00/02", q8[1].a, q8[1].d); end
    end
    vec++; if (ne8 != 0) begin bad++; $display("FAIL t3_err got %0d want 0", ne8); end
  endtask
`else
  task automatic test_overrun();
    int b1;
    clr(); open_f(); send(8'h05); send(8'h11); b1 = bs_cyc; send(8'h22);
    vec++; if (ne8 != 1) begin bad++; $display("FAIL t6_ovr_count got %0d want 1", ne8); end
    vec++; if (ec8 != bs_cyc + 1) begin bad++; $display("FAIL t6_ovr_cyc got %0d want %0d", ec8, bs_cyc + 1); end
    send(8'h33);
    vec++; if (ne8 != 1) begin bad++; $display("FAIL t6_ovr_once got %0d want 1", ne8); end
    vec++; if (q8.size() != 1) begin bad++; $display("FAIL t6_count got %0d want 1", q8.size()); end
    else begin
      vec++; if (q8[0].a !== 16'h05 || q8[0].d !== 16'h11 || q8[0].c != b1 + 1) begin
        bad++; $display("FAIL t6_word got %h/%h@%0d want 05/11@%0d", q8[0].a, q8[0].d, q8[0].c, b1 + 1); end
    end
    close_f();
    vec++; if (ne8 != 1) begin bad++; $display("FAIL t6_close_err got %0d want 1", ne8); end
  endtask
`endif

  task automatic test_reset_midframe();
    clr(); open_f(); send(8'h44);
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    vec++; if (st8 !== 2'b00) begin bad++; $display("FAIL rmid_state got %0h want 0", st8); end
    send(8'h07); send(8'h08); close_f();
    vec++; if (q8.size() != 0 || ne8 != 0) begin bad++; $display("FAIL rmid_ignored got %0d writes %0d errs want 0/0", q8.size(), ne8); end
    clr(); open_f(); send(8'h09); send(8'h0A); close_f();
    vec++; if (q8.size() != 1) begin bad++; $display("FAIL rmid_resume got %0d writes want 1", q8.size()); end
    else begin
      vec++; if (q8[0].a !== 16'h09 || q8[0].d !== 16'h0A) begin bad++; $display("FAIL rmid_word got %h/%h want 09/0a", q8[0].a, q8[0].d); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide();
    test_truncation();
    test_nss_race();
`ifdef SPI_BURST_EN
    test_burst();
    test_wrap();
`else
    test_overrun();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
